// File: rtl/sdram_dump_pkg.sv
// Shared state encodings and default sync-header bytes for the SDRAM-to-UART dumper.
package sdram_dump_pkg;

  localparam logic [7:0] HDR0_DEFAULT = 8'hA5;
  localparam logic [7:0] HDR1_DEFAULT = 8'h5A;

  // Dump sequencer; TX_DATA covers the per-byte states handled by uart_byte_sender.
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_REQ,
    RD_WAIT,
    TX_DATA,
    NEXT,
    FIN
  } dump_state_t;

  typedef enum logic [1:0] {
    TX_OFF,
    TX_SEND,
    TX_BUSY,
    TX_IDLE
  } tx_state_t;

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte UART handshake: strobe tx_en when the UART is ready, then wait for it
// to go busy and back to idle before reporting the byte as sent.
module uart_byte_sender
  import sdram_dump_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_byte,
  input  logic       go,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_en,
  output logic       idle,
  output logic       sent
);

  tx_state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TX_OFF;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: hold is the default before the case, so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      TX_OFF:  if (go)        state_nxt = TX_SEND;
      TX_SEND: if (tx_ready)  state_nxt = TX_BUSY;
      TX_BUSY: if (!tx_ready) state_nxt = TX_IDLE;
      TX_IDLE: if (tx_ready)  state_nxt = TX_OFF;
      default:                state_nxt = TX_OFF;
    endcase
  end

  // data_byte is held stable by the caller until sent, so it is sampled only at the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en   <= 1'b0;
      tx_byte <= 8'h00;
    end else begin
      tx_en <= (state == TX_SEND) && tx_ready;
      if ((state == TX_SEND) && tx_ready) tx_byte <= data_byte;
    end
  end

  assign idle = (state == TX_OFF);
  assign sent = (state == TX_IDLE) && tx_ready;

endmodule

// File: rtl/sdram_uart_dump.sv
// Streams SDRAM words 0..last_addr to a UART, MSB byte first, optionally preceded
// by a two-byte sync header; abort is honoured only between words.
module sdram_uart_dump
  import sdram_dump_pkg::*;
#(
  parameter int         ADDR_W    = 23,
  parameter int         HEADER_EN = 1,
  parameter logic [7:0] HDR0      = HDR0_DEFAULT,
  parameter logic [7:0] HDR1      = HDR1_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              cmd_ready,
  output logic              cmd_enable,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       data_out,
  input  logic              data_out_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_en,
  input  logic              tx_ready
);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] last_q;
  logic [1:0]        byte_idx;
  logic [31:0]       shreg;
  logic [7:0]        send_byte;
  logic              send_go;
  logic              send_idle;
  logic              sent;
  logic              last_word;

  assign last_word = (addr_cnt == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (HEADER_EN != 0) ? HDR : RD_REQ;
      HDR:     if (sent && (byte_idx == 2'd1)) state_nxt = RD_REQ;
      RD_REQ:  if (cmd_ready) state_nxt = RD_WAIT;
      RD_WAIT: if (data_out_ready) state_nxt = TX_DATA;
      TX_DATA: if (sent && (byte_idx == 2'd3)) state_nxt = NEXT;
      NEXT:    state_nxt = (abort || last_word) ? FIN : RD_REQ;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_enable  <= 1'b0;
      cmd_address <= '0;
      addr_cnt    <= '0;
      last_q      <= '0;
      byte_idx    <= 2'd0;
      shreg       <= 32'h0;
    end else begin
      // Strobe defaults low every cycle, so a read request lasts exactly one cycle.
      cmd_enable <= 1'b0;
      case (state)
        IDLE: if (start) begin
          last_q   <= last_addr;
          addr_cnt <= '0;
          byte_idx <= 2'd0;
        end
        HDR: if (sent) byte_idx <= byte_idx + 2'd1;
        RD_REQ: if (cmd_ready) begin
          cmd_enable  <= 1'b1;
          cmd_address <= addr_cnt;
        end
        RD_WAIT: if (data_out_ready) begin
          shreg    <= data_out;
          byte_idx <= 2'd0;
        end
        TX_DATA: if (sent) begin
          byte_idx <= byte_idx + 2'd1;
          shreg    <= {shreg[23:0], 8'h00};
        end
        NEXT: if (!(abort || last_word)) addr_cnt <= addr_cnt + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Header and data bytes share one sender; the top byte of shreg is always next out.
  assign send_byte = (state == HDR) ? ((byte_idx == 2'd0) ? HDR0 : HDR1) : shreg[31:24];
  assign send_go   = ((state == HDR) || (state == TX_DATA)) && send_idle;

  uart_byte_sender u_sender (
    .clk       (clk),
    .rst       (rst),
    .data_byte (send_byte),
    .go        (send_go),
    .tx_ready  (tx_ready),
    .tx_byte   (tx_byte),
    .tx_en     (tx_en),
    .idle      (send_idle),
    .sent      (sent)
  );

  assign busy   = (state != IDLE) && (state != FIN);
  assign done   = (state == FIN);
  assign cmd_wr = 1'b0;

endmodule

// File: tb/tb_sdram_uart_dump.sv
// Randomized bench for sdram_uart_dump: SDRAM and UART behavioural models plus an
// expected byte/address stream computed directly from memory contents.
module tb_sdram_uart_dump;

  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start2;
  logic [AW-1:0] last_addr;
  logic [1:0]    last_addr2;
  logic          abort;
  logic          cmd_ready;
  logic [31:0]   data_out;
  logic          data_out_ready;
  logic          tx_ready;

  logic          busy, done, cmd_enable, cmd_wr, tx_en;
  logic [AW-1:0] cmd_address;
  logic [7:0]    tx_byte;
  logic          busy2, done2, cmd_enable2, cmd_wr2, tx_en2;
  logic [1:0]    cmd_address2;
  logic [7:0]    tx_byte2;

  int errors = 0;
  int checks = 0;

  logic [31:0]       mem [16];
  logic [7:0]        rx_q[$];
  logic [7:0]        exp_bytes[$];
  int unsigned       addr_q[$];
  int unsigned       exp_addrs[$];
  int                done_cnt;
  logic              ctl_auto;

  always #5 clk = ~clk;

  sdram_uart_dump dut (
    .clk(clk), .rst(rst), .start(start), .last_addr(last_addr), .abort(abort),
    .busy(busy), .done(done), .cmd_ready(cmd_ready), .cmd_enable(cmd_enable),
    .cmd_wr(cmd_wr), .cmd_address(cmd_address), .data_out(data_out),
    .data_out_ready(data_out_ready), .tx_byte(tx_byte), .tx_en(tx_en), .tx_ready(tx_ready)
  );

  // Narrow, header-less variant so the all-ones last address is reachable.
  sdram_uart_dump #(.ADDR_W(2), .HEADER_EN(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .last_addr(last_addr2), .abort(abort),
    .busy(busy2), .done(done2), .cmd_ready(cmd_ready), .cmd_enable(cmd_enable2),
    .cmd_wr(cmd_wr2), .cmd_address(cmd_address2), .data_out(data_out),
    .data_out_ready(data_out_ready), .tx_byte(tx_byte2), .tx_en(tx_en2), .tx_ready(tx_ready)
  );

  logic          m_cmd_en, m_tx_en;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_tx_byte;
  assign m_cmd_en  = cmd_enable | cmd_enable2;
  assign m_addr    = cmd_enable2 ? AW'(cmd_address2) : cmd_address;
  assign m_tx_en   = tx_en | tx_en2;
  assign m_tx_byte = tx_en2 ? tx_byte2 : tx_byte;

  // UART model: goes busy for a random few cycles after each strobe.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (m_tx_en) begin
        rx_q.push_back(m_tx_byte);
        tx_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  // SDRAM model: logs every read command and answers after a random latency.
  initial begin
    int unsigned a;
    data_out_ready = 1'b0;
    data_out = 32'h0;
    forever begin
      @(negedge clk);
      if (m_cmd_en) begin
        a = int'(m_addr);
        addr_q.push_back(a);
        if (ctl_auto) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          data_out = mem[a % 16];
          data_out_ready = 1'b1;
          @(negedge clk);
          data_out_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (done || done2) done_cnt++;
    end
  end

  function automatic void build_expect(input bit hdr, input int nwords);
    exp_bytes.delete();
    exp_addrs.delete();
    if (hdr) begin
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(8'h5A);
    end
    for (int a = 0; a < nwords; a++) begin
      exp_addrs.push_back(a);
      for (int k = 3; k >= 0; k--) exp_bytes.push_back(8'(mem[a] >> (8 * k)));
    end
  endfunction

  function automatic int byte_diff();
    int d;
    d = (rx_q.size() != exp_bytes.size()) ? 1 : 0;
    for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++)
      if (rx_q[i] !== exp_bytes[i]) d++;
    return d;
  endfunction

  function automatic int addr_diff();
    int d;
    d = (addr_q.size() != exp_addrs.size()) ? 1 : 0;
    for (int i = 0; i < addr_q.size() && i < exp_addrs.size(); i++)
      if (addr_q[i] != exp_addrs[i]) d++;
    return d;
  endfunction

  function automatic void fill_mem_random();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    start = 1'b0; start2 = 1'b0; abort = 1'b0;
    last_addr = '0; last_addr2 = '0;
    cmd_ready = 1'b1; ctl_auto = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    rx_q.delete(); addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_dump(input bit second, input logic [AW-1:0] last);
    @(negedge clk);
    if (second) begin last_addr2 = last[1:0]; start2 = 1'b1; end
    else begin last_addr = last; start = 1'b1; end
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done || done2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within 5000 cycles, got 0 required 1", name);
    end
  endtask

  task automatic check_stream(input string name, input int exp_done);
    int d;
    repeat (3) @(negedge clk);
    d = byte_diff();
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL %s_bytes: got %0d bytes (%0d differences), required %0d bytes",
               name, rx_q.size(), d, exp_bytes.size());
    end
    d = addr_diff();
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL %s_addrs: got %0d reads (%0d differences), required %0d reads",
               name, addr_q.size(), d, exp_addrs.size());
    end
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL %s_done: got %0d done pulses, required %0d", name, done_cnt, exp_done);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({busy, done, cmd_enable, cmd_wr, tx_en, tx_byte, cmd_address} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b cmd_en=%b cmd_wr=%b tx_en=%b tx_byte=%h addr=%h, required all 0",
               busy, done, cmd_enable, cmd_wr, tx_en, tx_byte, cmd_address);
    end
    checks++;
    if ({busy2, done2, cmd_enable2, cmd_wr2, tx_en2, tx_byte2, cmd_address2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs2: got %b, required all 0",
               {busy2, done2, cmd_enable2, cmd_wr2, tx_en2, tx_byte2, cmd_address2});
    end
  endtask

  task automatic test_single_word();
    reset_dut();
    mem[0] = 32'h11223344;
    build_expect(1'b1, 1);
    start_dump(1'b0, '0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b required 1", busy);
    end
    wait_done("single");
    check_stream("single", 1);
  endtask

  task automatic test_words();
    reset_dut();
    for (int i = 0; i < 16; i++) mem[i] = i;
    build_expect(1'b1, 4);
    start_dump(1'b0, AW'(3));
    wait_done("index_words");
    check_stream("index_words", 1);
    for (int r = 0; r < 3; r++) begin
      int unsigned last;
      reset_dut();
      fill_mem_random();
      last = $urandom_range(0, 10);
      build_expect(1'b1, last + 1);
      start_dump(1'b0, AW'(last));
      wait_done($sformatf("random%0d", r));
      check_stream($sformatf("random%0d", r), 1);
    end
  endtask

  task automatic test_cmd_stall();
    int seen;
    reset_dut();
    fill_mem_random();
    build_expect(1'b1, 1);
    cmd_ready = 1'b0;
    start_dump(1'b0, '0);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_enable) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL stall_no_cmd: got %0d cmd_enable cycles, required 0", seen);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_enable !== 1'b1 || cmd_address !== '0) begin
      errors++;
      $display("FAIL stall_first_ready: got cmd_en=%b addr=%0d, required 1 at 0", cmd_enable, cmd_address);
    end
    wait_done("stall");
    check_stream("stall", 1);
  endtask

  task automatic test_abort();
    bit ok;
    reset_dut();
    fill_mem_random();
    build_expect(1'b1, 2);
    start_dump(1'b0, AW'(10));
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 8) abort = 1'b1;
      if (done) begin ok = 1'b1; break; end
    end
    abort = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_timeout: done not seen, got 0 required 1");
    end
    check_stream("abort", 1);
  endtask

  task automatic test_start_while_busy();
    reset_dut();
    fill_mem_random();
    build_expect(1'b1, 3);
    start_dump(1'b0, AW'(2));
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rebusy_busy: got %b required 1", busy);
    end
    start_dump(1'b0, AW'(7));
    wait_done("rebusy");
    repeat (20) @(negedge clk);
    check_stream("rebusy", 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rebusy_idle: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    reset_dut();
    fill_mem_random();
    start_dump(1'b0, AW'(5));
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 4) ctl_auto = 1'b0;
      if (addr_q.size() >= 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_second_read: second read not seen, got 0 required 1");
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cmd_enable, tx_en, tx_byte, cmd_address} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got busy=%b done=%b cmd_en=%b tx_en=%b tx_byte=%h addr=%h, required all 0",
               busy, done, cmd_enable, tx_en, tx_byte, cmd_address);
    end
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete(); addr_q.delete();
    done_cnt = 0;
    data_out = 32'hDEADBEEF;
    data_out_ready = 1'b1;
    @(negedge clk);
    data_out_ready = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (rx_q.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_late_data: got %0d bytes %0d done busy=%b, required 0 0 0",
               rx_q.size(), done_cnt, busy);
    end
    ctl_auto = 1'b1;
    fill_mem_random();
    build_expect(1'b1, 2);
    start_dump(1'b0, AW'(1));
    wait_done("rstmid_restart");
    check_stream("rstmid_restart", 1);
  endtask

  task automatic test_max_addr();
    reset_dut();
    fill_mem_random();
    build_expect(1'b0, 4);
    start_dump(1'b1, AW'(3));
    wait_done("maxaddr");
    check_stream("maxaddr", 1);
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL maxaddr_idle: got busy=%b required 0", busy2);
    end
  endtask

  initial begin
    rst = 1'b1;
    ctl_auto = 1'b1;
    test_reset();
    test_single_word();
    test_words();
    test_cmd_stall();
    test_abort();
    test_start_while_busy();
    test_reset_mid_dump();
    test_max_addr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_uart_dump.md
SDRAM_UART_DUMP -- requirements
Module: sdram_uart_dump

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, meaning SDRAM word-address width.
REQ-002 SHALL have parameter HEADER_EN, default 1, meaning 1 = send sync header before the stream.
REQ-003 SHALL have parameter HDR0, default 8'hA5, meaning first header byte.
REQ-004 SHALL have parameter HDR1, default 8'h5A, meaning second header byte.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is clocked on the rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-007 SHALL have port start, input, 1, meaning one-cycle dump request.
REQ-008 SHALL have port last_addr, input, ADDR_W, meaning last word address to dump (inclusive); sampled when start is accepted.
REQ-009 SHALL have port abort, input, 1, meaning level request to stop at the next word boundary.
REQ-010 SHALL have port busy, output, 1, meaning a dump is in progress.
REQ-011 SHALL have port done, output, 1, meaning one-cycle pulse at end of dump, normal or aborted.
REQ-012 SHALL have port cmd_ready, input, 1, meaning the SDRAM controller can accept a command.
REQ-013 SHALL have port cmd_enable, output, 1, meaning command strobe.
REQ-014 SHALL have port cmd_wr, output, 1, meaning write select; tied 0 (read only).
REQ-015 SHALL have port cmd_address, output, ADDR_W, meaning read address.
REQ-016 SHALL have port data_out, input, 32, meaning read data from the controller.
REQ-017 SHALL have port data_out_ready, input, 1, meaning data_out is valid this cycle.
REQ-018 SHALL have port tx_byte, output, 8, meaning byte to the UART.
REQ-019 SHALL have port tx_en, output, 1, meaning one-cycle UART send strobe.
REQ-020 SHALL have port tx_ready, input, 1, meaning the UART is idle and can accept a byte.

Function
REQ-021 SHALL implement FSM states IDLE, HDR, RD_REQ, RD_WAIT, TX_SEND, TX_BUSY, TX_IDLE, NEXT, FIN.
REQ-022 SHALL, in IDLE, go on start to HDR if HEADER_EN=1, else to RD_REQ; this cycle SHALL latch last_addr, clear the address counter to 0 and set busy=1 from the next cycle.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, in HDR, send HDR0 then HDR1 using the byte handshake of REQ-027..029, then go to RD_REQ.
REQ-025 SHALL, in RD_REQ, assert cmd_enable for exactly one cycle when cmd_ready=1, with cmd_address equal to the address counter, then go to RD_WAIT; cmd_enable SHALL stay 0 while cmd_ready=0.
REQ-026 SHALL, in RD_WAIT, capture data_out into a 32-bit shift register on the first data_out_ready=1 cycle, clear the byte index, and go to TX_SEND; data_out_ready outside RD_WAIT SHALL be ignored.
REQ-027 SHALL, in TX_SEND, drive tx_byte from the shift register, MSB byte first (bits 31:24, then 23:16, 15:8, 7:0), and pulse tx_en for one cycle when tx_ready=1.
REQ-028 SHALL, in TX_BUSY, wait for tx_ready=0.
REQ-029 SHALL, in TX_IDLE, wait for tx_ready=1; then go to TX_SEND if the byte index is below 3, else to NEXT; the byte index SHALL increment on each tx_en pulse.
REQ-030 SHALL, in NEXT, go to FIN if abort=1 or the address counter equals the latched last_addr; otherwise increment the address by 1 and go to RD_REQ.
REQ-031 SHALL not wrap the address counter; last_addr = 2^ADDR_W-1 SHALL terminate at that address.
REQ-032 SHALL dump exactly one word when last_addr=0.
REQ-033 SHALL ignore abort in every state except NEXT; an abort while a read or byte is pending SHALL complete that word first.
REQ-034 SHALL, in FIN, pulse done for one cycle, set busy=0 on the same cycle and return to IDLE.
REQ-035 SHALL make tx_byte, tx_en, cmd_enable and cmd_address registered outputs.

Reset
REQ-036 SHALL, on rst=1, go to IDLE immediately, regardless of clock.
REQ-037 SHALL reset busy, done, cmd_enable, cmd_wr, tx_en to 0, and cmd_address, tx_byte, the address counter, the byte index and the shift register to 0.
REQ-038 SHALL, when rst is asserted mid-dump, abandon the dump with no done pulse; a late data_out_ready after reset SHALL be ignored.

Structure
REQ-039 SHALL place the state encodings and the default header constants in a shared package, sdram_dump_pkg.
REQ-040 SHALL have one natural sub-module, uart_byte_sender, containing TX_SEND/TX_BUSY/TX_IDLE (inputs byte and go, output sent); HDR and the data path SHALL both reuse it.

Verification
REQ-041 SHALL cover: HEADER_EN=1, last_addr=0, memory word 0x11223344 -> UART bytes A5,5A,11,22,33,44; one done pulse; exactly one cmd_enable pulse, at address 0.
REQ-042 SHALL cover: last_addr=3, memory[i]=i -> 16 data bytes 00,00,00,00 ... 00,00,00,03; cmd_address sequence 0,1,2,3.
REQ-043 SHALL cover: cmd_ready held 0 for 50 cycles -> cmd_enable stays 0; read issued on the first cycle cmd_ready=1.
REQ-044 SHALL cover: abort asserted during the second byte of word 1 (last_addr=10) -> word 1 fully sent, no read at address 2, done pulses.
REQ-045 SHALL cover: start pulsed again while busy -> ignored; byte count unchanged.
REQ-046 SHALL cover: rst pulsed in RD_WAIT, then data_out_ready -> outputs at reset values, no tx_en, no done; a new start runs normally.
